// File: rtl/i2c_pkg.sv
// Shared types and defaults for the I2C bus-condition front end.
package i2c_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } bus_state_e;

   // Filtered-domain bus events, decoded from current vs. previous filtered levels.
   typedef struct packed {
      logic scl_rise;
      logic scl_fall;
      logic start;
      logic stop;
   } bus_ev_t;

   localparam logic [3:0] ACK_SLOT        = 4'd8;
   localparam int         SYNC_STAGES_DEF = 2;
   localparam int         FILT_LEN_DEF    = 3;

endpackage

// File: rtl/i2c_bus_cond_detect_if.sv
// Pad-side pins and decoded bus status of the I2C condition detector.
interface i2c_bus_cond_detect_if;

   logic       SCLPin;
   logic       SDAPin;
   logic       SCLF;
   logic       SDAF;
   logic       SCLRise;
   logic       SCLFall;
   logic       START;
   logic       STOP;
   logic       BusBusy;
   logic [3:0] BitCnt;
   logic [7:0] RxByte;
   logic       ByteValid;
   logic       AckBit;
   logic       AckValid;
   logic       BusErr;

   // master: pad / stimulus side; slave: the detector
   modport master (
      output SCLPin, SDAPin,
      input  SCLF, SDAF, SCLRise, SCLFall, START, STOP, BusBusy,
      input  BitCnt, RxByte, ByteValid, AckBit, AckValid, BusErr
   );

   modport slave (
      input  SCLPin, SDAPin,
      output SCLF, SDAF, SCLRise, SCLFall, START, STOP, BusBusy,
      output BitCnt, RxByte, ByteValid, AckBit, AckValid, BusErr
   );

endinterface

// File: rtl/i2c_glitch_filter.sv
// Pin synchroniser followed by a stability counter; the output level flips only
// after the synchronised input has disagreed with it for FILT_LEN cycles in a row.
module i2c_glitch_filter
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILT_LEN    = FILT_LEN_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic pin_i,
   output logic filt_o
);

   localparam int CW = $clog2(FILT_LEN + 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   filt_q, filt_d;
   logic                   samp;

   assign samp   = sync_q[SYNC_STAGES-1];
   assign filt_o = filt_q;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
      filt_d = filt_q;
      cnt_d  = '0;
      if (samp != filt_q) begin
         if (cnt_q == CW'(FILT_LEN - 1)) filt_d = samp;
         else                            cnt_d  = cnt_q + CW'(1);
      end
   end

   // Idle bus is high, so the chain and level come out of reset at 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '1;
         cnt_q  <= '0;
         filt_q <= 1'b1;
      end else begin
         sync_q <= sync_d;
         cnt_q  <= cnt_d;
         filt_q <= filt_d;
      end
   end

endmodule

// File: rtl/i2c_bus_cond_detect.sv
// I2C front end: deglitched SCL/SDA, START/STOP and SCL edge strobes, bit/byte
// framing with ACK capture, and an SCL-held-low bus hang timeout.
module i2c_bus_cond_detect
   import i2c_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int FILT_LEN    = FILT_LEN_DEF,
   parameter int TIMEOUT     = 4096,
   parameter int TO_W        = 13
) (
   input  logic                  CLK,
   input  logic                  RESET,
   i2c_bus_cond_detect_if.slave  bus
);

   logic       sclf, sdaf;
   logic       sclf_prev_q, sdaf_prev_q;
   bus_ev_t    ev;
   logic       busy, to_hit;

   bus_state_e state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [6:0] shift_q, shift_d;
   logic [7:0] rx_byte_q, rx_byte_d;
   logic       ack_bit_q, ack_bit_d;
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;
   logic       scl_rise_q, scl_rise_d;
   logic       scl_fall_q, scl_fall_d;
   logic       start_q, start_d;
   logic       stop_q, stop_d;
   logic       byte_valid_q, byte_valid_d;
   logic       ack_valid_q, ack_valid_d;
   logic       bus_err_q, bus_err_d;

   i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_filt (
      .clk(CLK), .rst(RESET), .pin_i(bus.SCLPin), .filt_o(sclf)
   );

   i2c_glitch_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_filt (
      .clk(CLK), .rst(RESET), .pin_i(bus.SDAPin), .filt_o(sdaf)
   );

   // START/STOP need SCL high on both sides, so a simultaneous SCL+SDA change
   // yields only the SCL strobe.
   always_comb begin
      ev.scl_rise = sclf & ~sclf_prev_q;
      ev.scl_fall = ~sclf & sclf_prev_q;
      ev.start    = sclf & sclf_prev_q & sdaf_prev_q & ~sdaf;
      ev.stop     = sclf & sclf_prev_q & ~sdaf_prev_q & sdaf;
   end

   assign busy   = (state_q == BUSY);
   assign to_hit = busy && !sclf && (to_cnt_q == TO_W'(TIMEOUT - 1));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ev.start) state_d = BUSY;
         BUSY:    if (ev.stop || to_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      rx_byte_d    = rx_byte_q;
      ack_bit_d    = ack_bit_q;
      byte_valid_d = 1'b0;
      ack_valid_d  = 1'b0;
      bus_err_d    = 1'b0;
      scl_rise_d   = ev.scl_rise;
      scl_fall_d   = ev.scl_fall;
      start_d      = ev.start;
      stop_d       = ev.stop;

      to_cnt_d = '0;
      if (busy && !sclf)
         to_cnt_d = (to_cnt_q == TO_W'(TIMEOUT)) ? to_cnt_q : to_cnt_q + TO_W'(1);

      // Conditions outrank framing; the timeout can never coincide with them
      // since it needs SCL low.
      if (ev.start || (busy && ev.stop)) begin
         bit_cnt_d = 4'd0;
         shift_d   = '0;
      end else if (busy && ev.scl_rise) begin
         if (bit_cnt_q == ACK_SLOT) begin
            ack_bit_d   = sdaf;
            ack_valid_d = 1'b1;
            bit_cnt_d   = 4'd0;
         end else begin
            shift_d = {shift_q[5:0], sdaf};
            if (bit_cnt_q == 4'd7) begin
               rx_byte_d    = {shift_q, sdaf};
               byte_valid_d = 1'b1;
            end
            bit_cnt_d = bit_cnt_q + 4'd1;
         end
      end else if (to_hit) begin
         bus_err_d = 1'b1;
         bit_cnt_d = 4'd0;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sclf_prev_q  <= 1'b1;
         sdaf_prev_q  <= 1'b1;
         bit_cnt_q    <= 4'd0;
         shift_q      <= '0;
         rx_byte_q    <= 8'd0;
         ack_bit_q    <= 1'b1;
         to_cnt_q     <= '0;
         scl_rise_q   <= 1'b0;
         scl_fall_q   <= 1'b0;
         start_q      <= 1'b0;
         stop_q       <= 1'b0;
         byte_valid_q <= 1'b0;
         ack_valid_q  <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         sclf_prev_q  <= sclf;
         sdaf_prev_q  <= sdaf;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         rx_byte_q    <= rx_byte_d;
         ack_bit_q    <= ack_bit_d;
         to_cnt_q     <= to_cnt_d;
         scl_rise_q   <= scl_rise_d;
         scl_fall_q   <= scl_fall_d;
         start_q      <= start_d;
         stop_q       <= stop_d;
         byte_valid_q <= byte_valid_d;
         ack_valid_q  <= ack_valid_d;
         bus_err_q    <= bus_err_d;
      end
   end

   assign bus.SCLF      = sclf;
   assign bus.SDAF      = sdaf;
   assign bus.SCLRise   = scl_rise_q;
   assign bus.SCLFall   = scl_fall_q;
   assign bus.START     = start_q;
   assign bus.STOP      = stop_q;
   assign bus.BusBusy   = busy;
   assign bus.BitCnt    = bit_cnt_q;
   assign bus.RxByte    = rx_byte_q;
   assign bus.ByteValid = byte_valid_q;
   assign bus.AckBit    = ack_bit_q;
   assign bus.AckValid  = ack_valid_q;
   assign bus.BusErr    = bus_err_q;

endmodule

// File: tb/tb_i2c_bus_cond_detect.sv
// Directed bench for i2c_bus_cond_detect: bus transactions driven on the pins,
// pulse counts and captured values checked against hand-computed values.
module tb_i2c_bus_cond_detect;

   localparam int TIMEOUT = 4096;

   logic CLK = 1'b0;
   logic RESET;
   int   errors = 0;
   int   checks = 0;

   int n_start = 0, n_stop = 0, n_rise = 0, n_fall = 0;
   int n_bv = 0, n_av = 0, n_err = 0;
   logic [7:0] last_rx = 8'h00;

   int b_start, b_stop, b_rise, b_fall, b_bv, b_av, b_err;
   logic bad;

   i2c_bus_cond_detect_if bus ();

   i2c_bus_cond_detect #(.TIMEOUT(TIMEOUT), .TO_W(13)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   // Pulses are registered at posedge; sample once per cycle shortly after.
   always @(posedge CLK) begin
      #1;
      if (bus.START)     n_start++;
      if (bus.STOP)      n_stop++;
      if (bus.SCLRise)   n_rise++;
      if (bus.SCLFall)   n_fall++;
      if (bus.AckValid)  n_av++;
      if (bus.BusErr)    n_err++;
      if (bus.ByteValid) begin
         n_bv++;
         last_rx = bus.RxByte;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic snap();
      b_start = n_start; b_stop = n_stop; b_rise = n_rise; b_fall = n_fall;
      b_bv = n_bv; b_av = n_av; b_err = n_err;
   endtask

   // Bus idle (both high) -> START, leaves SCL low.
   task automatic i2c_start();
      bus.SDAPin = 1'b0; wait_cyc(20);
      bus.SCLPin = 1'b0; wait_cyc(20);
   endtask

   // SCL low on entry and exit; SDA changes only while SCL is low.
   task automatic send_bit(input logic b);
      bus.SDAPin = b;    wait_cyc(10);
      bus.SCLPin = 1'b1; wait_cyc(20);
      bus.SCLPin = 1'b0; wait_cyc(10);
   endtask

   task automatic send_byte(input logic [7:0] d);
      for (int i = 7; i >= 0; i--) send_bit(d[i]);
   endtask

   task automatic i2c_stop();
      bus.SDAPin = 1'b0; wait_cyc(10);
      bus.SCLPin = 1'b1; wait_cyc(20);
      bus.SDAPin = 1'b1; wait_cyc(20);
   endtask

   task automatic i2c_rstart();
      bus.SDAPin = 1'b1; wait_cyc(10);
      bus.SCLPin = 1'b1; wait_cyc(20);
      bus.SDAPin = 1'b0; wait_cyc(20);
      bus.SCLPin = 1'b0; wait_cyc(10);
   endtask

   initial begin
      RESET = 1'b1;
      bus.SCLPin = 1'b1;
      bus.SDAPin = 1'b1;
      wait_cyc(3);
      chk("rst_sclf",   32'(bus.SCLF),    32'd1);
      chk("rst_sdaf",   32'(bus.SDAF),    32'd1);
      chk("rst_busy",   32'(bus.BusBusy), 32'd0);
      chk("rst_bitcnt", 32'(bus.BitCnt),  32'd0);
      chk("rst_rxbyte", 32'(bus.RxByte),  32'h00);
      chk("rst_ackbit", 32'(bus.AckBit),  32'd1);

      // idle bus after reset
      RESET = 1'b0;
      snap();
      wait_cyc(100);
      chk("idle_sclf", 32'(bus.SCLF),    32'd1);
      chk("idle_sdaf", 32'(bus.SDAF),    32'd1);
      chk("idle_busy", 32'(bus.BusBusy), 32'd0);
      chk("idle_pulses", 32'(n_start + n_stop + n_rise + n_fall + n_bv + n_av + n_err), 32'd0);

      // START, 0xA0, ACK, STOP
      snap();
      i2c_start();
      chk("t2_start_cnt", 32'(n_start - b_start), 32'd1);
      chk("t2_busy_on",   32'(bus.BusBusy),       32'd1);
      send_byte(8'hA0);
      chk("t2_bitcnt_ack", 32'(bus.BitCnt),     32'd8);
      chk("t2_bv_cnt",     32'(n_bv - b_bv),    32'd1);
      chk("t2_rx_last",    32'(last_rx),        32'hA0);
      chk("t2_rxbyte",     32'(bus.RxByte),     32'hA0);
      send_bit(1'b0);
      chk("t2_av_cnt",     32'(n_av - b_av),    32'd1);
      chk("t2_ackbit",     32'(bus.AckBit),     32'd0);
      chk("t2_bitcnt_wrap", 32'(bus.BitCnt),    32'd0);
      chk("t2_busy_mid",   32'(bus.BusBusy),    32'd1);
      i2c_stop();
      chk("t2_stop_cnt",   32'(n_stop - b_stop),   32'd1);
      chk("t2_start_once", 32'(n_start - b_start), 32'd1);
      chk("t2_busy_off",   32'(bus.BusBusy),       32'd0);
      chk("t2_rise_cnt",   32'(n_rise - b_rise),   32'd10);

      // SDA glitch of FILT_LEN-1 cycles with SCL high
      snap();
      bad = 1'b0;
      bus.SDAPin = 1'b0; wait_cyc(2);
      bus.SDAPin = 1'b1;
      for (int i = 0; i < 12; i++) begin
         wait_cyc(1);
         bad = bad | ~bus.SDAF;
      end
      chk("t3_sdaf_low_seen", 32'(bad), 32'd0);
      chk("t3_no_cond", 32'((n_start - b_start) + (n_stop - b_stop)), 32'd0);

      // repeated START after 4 bits, then 0x5A with NACK
      snap();
      i2c_start();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      chk("t4_bitcnt4", 32'(bus.BitCnt), 32'd4);
      i2c_rstart();
      chk("t4_bitcnt_rs", 32'(bus.BitCnt),        32'd0);
      chk("t4_start_cnt", 32'(n_start - b_start), 32'd2);
      chk("t4_busy",      32'(bus.BusBusy),       32'd1);
      send_byte(8'h5A);
      send_bit(1'b1);
      chk("t4_bv_cnt",  32'(n_bv - b_bv), 32'd1);
      chk("t4_rx_last", 32'(last_rx),     32'h5A);
      chk("t4_ackbit",  32'(bus.AckBit),  32'd1);
      i2c_stop();
      chk("t4_busy_off", 32'(bus.BusBusy), 32'd0);

      // SCL held low past the timeout
      snap();
      i2c_start();
      send_bit(1'b1); send_bit(1'b0);
      wait_cyc(TIMEOUT - 100);
      chk("t5_no_err_early", 32'(n_err - b_err), 32'd0);
      chk("t5_busy_early",   32'(bus.BusBusy),   32'd1);
      chk("t5_bitcnt_early", 32'(bus.BitCnt),    32'd2);
      wait_cyc(200);
      chk("t5_err_cnt", 32'(n_err - b_err), 32'd1);
      chk("t5_busy",    32'(bus.BusBusy),   32'd0);
      chk("t5_bitcnt",  32'(bus.BitCnt),    32'd0);
      wait_cyc(100);
      chk("t5_err_once", 32'(n_err - b_err), 32'd1);
      // release: SCL rise then SDA rise -> STOP while IDLE
      bus.SCLPin = 1'b1; wait_cyc(20);
      bus.SDAPin = 1'b1; wait_cyc(20);
      chk("t5_idle_stop", 32'(n_stop - b_stop), 32'd1);
      chk("t5_idle_busy", 32'(bus.BusBusy),     32'd0);

      // SCL and SDA change together while SCL high
      snap();
      bus.SCLPin = 1'b0; bus.SDAPin = 1'b0; wait_cyc(20);
      chk("t6_fall_cnt", 32'(n_fall - b_fall),   32'd1);
      chk("t6_no_start", 32'(n_start - b_start), 32'd0);
      bus.SCLPin = 1'b1; bus.SDAPin = 1'b1; wait_cyc(20);
      chk("t6_rise_cnt", 32'(n_rise - b_rise), 32'd1);
      chk("t6_no_stop",  32'(n_stop - b_stop), 32'd0);
      chk("t6_busy",     32'(bus.BusBusy),     32'd0);

      // RESET mid-byte
      i2c_start();
      send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
      chk("t6_pre_bitcnt", 32'(bus.BitCnt), 32'd3);
      RESET = 1'b1;
      #1;
      chk("t6_rst_busy",   32'(bus.BusBusy), 32'd0);
      chk("t6_rst_bitcnt", 32'(bus.BitCnt),  32'd0);
      chk("t6_rst_rxbyte", 32'(bus.RxByte),  32'h00);
      chk("t6_rst_ackbit", 32'(bus.AckBit),  32'd1);
      chk("t6_rst_sclf",   32'(bus.SCLF),    32'd1);
      chk("t6_rst_sdaf",   32'(bus.SDAF),    32'd1);
      wait_cyc(2);
      bus.SCLPin = 1'b1; bus.SDAPin = 1'b1;
      wait_cyc(2);
      RESET = 1'b0;
      wait_cyc(20);
      // clocking without a new START must not frame
      bus.SCLPin = 1'b0; wait_cyc(20);
      snap();
      send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      chk("t6_noframe_bitcnt", 32'(bus.BitCnt),     32'd0);
      chk("t6_noframe_busy",   32'(bus.BusBusy),    32'd0);
      chk("t6_noframe_rise",   32'(n_rise - b_rise), 32'd3);
      bus.SDAPin = 1'b1; wait_cyc(10);
      bus.SCLPin = 1'b1; wait_cyc(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
